// File: rtl/u_alu_issue.sv
// u_alu_issue: RV32I issue stage decoding ALU op/operands into a 2-entry skid FIFO
module u_alu_issue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_i1,
    output logic [XLEN-1:0] alu_i2,
    output logic [2:0]      out_br,
    output logic            out_isbr,
    output logic [XLEN-1:0] out_rs2,
    output logic            out_ill
);
    typedef struct packed {
        logic [3:0]      op;
        logic [XLEN-1:0] i1;
        logic [XLEN-1:0] i2;
        logic [XLEN-1:0] rs2;
        logic [2:0]      br;
        logic            isbr;
        logic            ill;
    } uop_t;

    uop_t            dec;
    uop_t            mem [DEPTH];
    logic            rd_ptr, wr_ptr;
    logic [1:0]      count, count_next;
    logic            push, pop;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_u, shamt;

    assign f3    = in_instr[14:12];
    assign f7    = in_instr[31:25];
    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign shamt = {27'b0, in_instr[24:20]};

    // decode the incoming instruction into an ALU micro-op
    always_comb begin
        dec     = '0;
        dec.rs2 = in_rs2;
        case (in_instr[6:0])
            7'b0110011: begin
                dec.op  = {in_instr[30], f3};
                dec.i1  = in_rs1;
                dec.i2  = in_rs2;
                dec.ill = !(f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            7'b0010011: begin
                dec.i1  = in_rs1;
                dec.i2  = (f3 == 3'b001 || f3 == 3'b101) ? shamt : imm_i;
                dec.op  = {f3 == 3'b101 && f7 == 7'b0100000, f3};
                dec.ill = f3 == 3'b001 ? f7 != 7'b0 :
                          f3 == 3'b101 ? (f7 != 7'b0 && f7 != 7'b0100000) : 1'b0;
            end
            7'b0110111: dec.i2 = imm_u;
            7'b0010111: begin
                dec.i1 = in_pc;
                dec.i2 = imm_u;
            end
            7'b1101111, 7'b1100111: begin
                dec.i1 = in_pc;
                dec.i2 = 32'd4;
            end
            7'b1100011: begin
                dec.isbr = 1'b1;
                dec.br   = f3;
                dec.i1   = in_rs1;
                dec.i2   = in_rs2;
                dec.op   = f3[2:1] == 2'b11 ? 4'b0011 : f3[2:1] == 2'b10 ? 4'b0010 : 4'b1000;
                dec.ill  = f3[2:1] == 2'b01;
            end
            7'b0000011: begin
                dec.i1 = in_rs1;
                dec.i2 = imm_i;
            end
            7'b0100011: begin
                dec.i1 = in_rs1;
                dec.i2 = imm_s;
            end
            default: dec.ill = 1'b1;
        endcase
    end

    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign count_next = count + {1'b0, push} - {1'b0, pop};

    // in-order FIFO storage; in_ready registered from post-edge occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            in_ready <= 1'b1;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec;
                wr_ptr      <= !wr_ptr;
            end
            if (pop) rd_ptr <= !rd_ptr;
            count    <= count_next;
            in_ready <= count_next <= 2'd1;
        end
    end

    assign out_valid = count != 2'd0;
    assign alu_op    = mem[rd_ptr].op;
    assign alu_i1    = mem[rd_ptr].i1;
    assign alu_i2    = mem[rd_ptr].i2;
    assign out_rs2   = mem[rd_ptr].rs2;
    assign out_br    = mem[rd_ptr].br;
    assign out_isbr  = mem[rd_ptr].isbr;
    assign out_ill   = mem[rd_ptr].ill;
endmodule

// File: tb/tb_u_alu_issue.sv
// tb_u_alu_issue: directed plus randomized scoreboard bench for u_alu_issue
module tb_u_alu_issue;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [31:0] in_instr = '0, in_pc = '0, in_rs1 = '0, in_rs2 = '0;
    logic [3:0]  alu_op;
    logic [31:0] alu_i1, alu_i2, out_rs2;
    logic [2:0]  out_br;
    logic        out_isbr, out_ill;
    int          checks = 0, failures = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] i1, i2, rs2;
        logic [2:0]  br;
        logic        isbr, ill, full, crs2;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    u_alu_issue dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
        .alu_i1(alu_i1), .alu_i2(alu_i2), .out_br(out_br), .out_isbr(out_isbr),
        .out_rs2(out_rs2), .out_ill(out_ill)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        logic [2:0]  f3 = ins[14:12];
        logic [6:0]  f7 = ins[31:25];
        logic [31:0] imm_i = {{20{ins[31]}}, ins[31:20]};
        logic [31:0] imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        logic [31:0] upper = ins & 32'hFFFF_F000;
        logic [3:0]  base = {1'b0, f3};
        logic [3:0]  sub_bias = (f7 == 7'h20) ? 4'd8 : 4'd0;
        e = '{op: 4'd0, i1: 32'd0, i2: 32'd0, rs2: r2, br: 3'd0, isbr: 1'b0, ill: 1'b0, full: 1'b1, crs2: 1'b0};
        case (ins[6:0])
            7'h33: begin
                e.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
                e.full = !e.ill;
                e.op = base + sub_bias;
                e.i1 = r1;
                e.i2 = r2;
            end
            7'h13: begin
                e.i1 = r1;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.i2 = {27'd0, ins[24:20]};
                    e.ill = !(f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20));
                    e.full = !e.ill;
                    e.op = base + sub_bias;
                end else begin
                    e.i2 = imm_i;
                    e.op = base;
                end
            end
            7'h37: e.i2 = upper;
            7'h17: begin e.i1 = pc; e.i2 = upper; end
            7'h6f, 7'h67: begin e.i1 = pc; e.i2 = 32'd4; end
            7'h63: begin
                e.isbr = 1'b1;
                e.br = f3;
                e.i1 = r1;
                e.i2 = r2;
                e.ill = (f3 == 3'd2 || f3 == 3'd3);
                e.full = !e.ill;
                e.op = (f3 < 3'd2) ? 4'd8 : (f3 >= 3'd6) ? 4'd3 : 4'd2;
            end
            7'h03: begin e.i1 = r1; e.i2 = imm_i; e.crs2 = 1'b1; end
            7'h23: begin e.i1 = r1; e.i2 = imm_s; e.crs2 = 1'b1; end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w = $urandom;
        logic [6:0]  f7s [4] = '{7'h00, 7'h20, 7'h01, 7'h7f};
        case ($urandom_range(0, 9))
            0: begin w[6:0] = 7'h33; w[31:25] = f7s[$urandom_range(0, 3)]; end
            1: begin w[6:0] = 7'h13; w[31:25] = f7s[$urandom_range(0, 3)]; end
            2: w[6:0] = 7'h37;
            3: w[6:0] = 7'h17;
            4: w[6:0] = 7'h6f;
            5: w[6:0] = 7'h67;
            6: w[6:0] = 7'h63;
            7: w[6:0] = 7'h03;
            8: w[6:0] = 7'h23;
            default: ;
        endcase
        return w;
    endfunction

    task automatic check_head();
        if (out_valid && q.size() > 0) begin
            chk("head_ill", 32'(out_ill), 32'(q[0].ill));
            if (q[0].full) begin
                chk("head_op", 32'(alu_op), 32'(q[0].op));
                chk("head_i1", alu_i1, q[0].i1);
                chk("head_i2", alu_i2, q[0].i2);
                chk("head_isbr", 32'(out_isbr), 32'(q[0].isbr));
                if (q[0].isbr) chk("head_br", 32'(out_br), 32'(q[0].br));
            end
            if (q[0].crs2) chk("head_rs2", out_rs2, q[0].rs2);
        end
    endtask

    task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2, input logic ordy);
        logic acc, pp;
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() <= 1));
        check_head();
        in_valid = iv; in_instr = ins; in_pc = pc; in_rs1 = r1; in_rs2 = r2; out_ready = ordy;
        acc = iv && (q.size() <= 1);
        pp  = ordy && (q.size() != 0);
        @(posedge clk);
        if (pp) q.delete(0);
        if (acc) q.push_back(model(ins, pc, r1, r2));
    endtask

    task automatic direct(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        cycle(1'b1, ins, 32'h0000_1000, r1, r2, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        #1;
    endtask

    task automatic drain();
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    endtask

    initial begin
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_op", 32'(alu_op), 32'd0);
        chk("rst_i1", alu_i1, 32'd0);
        chk("rst_i2", alu_i2, 32'd0);
        chk("rst_rs2", out_rs2, 32'd0);
        chk("rst_br", 32'(out_br), 32'd0);
        chk("rst_isbr", 32'(out_isbr), 32'd0);
        chk("rst_ill", 32'(out_ill), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        direct(32'h4001_0093, 32'd5, 32'd0);
        chk("addi_op", 32'(alu_op), 32'd0);
        chk("addi_i1", alu_i1, 32'd5);
        chk("addi_i2", alu_i2, 32'h400);
        chk("addi_ill", 32'(out_ill), 32'd0);
        drain();
        direct(32'h4020_8033, 32'd9, 32'd4);
        chk("sub_op", 32'(alu_op), 32'h8);
        chk("sub_i1", alu_i1, 32'd9);
        chk("sub_i2", alu_i2, 32'd4);
        drain();
        direct(32'h4031_5093, 32'd7, 32'd0);
        chk("srai_op", 32'(alu_op), 32'hd);
        chk("srai_i2", alu_i2, 32'd3);
        drain();
        direct(32'h4031_1093, 32'd7, 32'd0);
        chk("slli_bad_ill", 32'(out_ill), 32'd1);
        drain();
        direct(32'h0020_E063, 32'd1, 32'd2);
        chk("bltu_op", 32'(alu_op), 32'h3);
        chk("bltu_isbr", 32'(out_isbr), 32'd1);
        chk("bltu_br", 32'(out_br), 32'h6);
        drain();
        direct(32'h1234_50B7, 32'd3, 32'd0);
        chk("lui_i1", alu_i1, 32'd0);
        chk("lui_i2", alu_i2, 32'h1234_5000);
        drain();

        cycle(1'b1, 32'h0000_0033, 32'h0, 32'd1, 32'd10, 1'b0);
        cycle(1'b1, 32'h0000_0033, 32'h0, 32'd2, 32'd20, 1'b0);
        cycle(1'b1, 32'h0000_0033, 32'h0, 32'd3, 32'd30, 1'b0);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_hold_i1", alu_i1, 32'd1);
        cycle(1'b1, 32'h0000_0033, 32'h0, 32'd3, 32'd30, 1'b0);
        cycle(1'b1, 32'h0000_0033, 32'h0, 32'd3, 32'd30, 1'b1);
        cycle(1'b1, 32'h0000_0033, 32'h0, 32'd3, 32'd30, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1);
        drain();

        for (int i = 0; i < 20; i++) cycle(1'b1, rnd_instr(), $urandom, $urandom, $urandom, 1'b1);
        #1 chk("stream_in_ready", 32'(in_ready), 32'd1);
        drain();

        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 9) < 7), rnd_instr(), $urandom, $urandom, $urandom,
                  1'($urandom_range(0, 9) < 6));
        drain();

        cycle(1'b1, 32'h0000_0033, 32'h0, 32'd4, 32'd0, 1'b0);
        cycle(1'b1, 32'h0000_0033, 32'h0, 32'd5, 32'd0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        @(negedge clk) rst_n = 1'b1;
        cycle(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
